// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath: FSM encoding
// and latency helpers.
package rsa_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_REDUCE = 3'd2;
   localparam logic [2:0] ST_MUL_R  = 3'd3;
   localparam logic [2:0] ST_SQR    = 3'd4;
   localparam logic [2:0] ST_NEXT   = 3'd5;
   localparam logic [2:0] ST_FINISH = 3'd6;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      CHECK  = ST_CHECK,
      REDUCE = ST_REDUCE,
      MUL_R  = ST_MUL_R,
      SQR    = ST_SQR,
      NEXT   = ST_NEXT,
      FINISH = ST_FINISH
   } state_e;

   // Cycles from multiplier launch to its done pulse.
   function automatic int unsigned mul_lat(input int unsigned w);
      return w + 1;
   endfunction

   // Start-edge to done-high latency of the exponentiation engine.
   function automatic int unsigned exp_latency(input int unsigned w,
                                               input logic [63:0] e,
                                               input logic [63:0] m);
      int unsigned pop;
      int unsigned len;
      pop = 0;
      len = 0;
      if (m < 64'd2 || e == 64'd0) return 2;
      for (int i = 0; i < 64; i++) begin
         if (e[i]) begin
            pop = pop + 1;
            len = 32'(i + 1);
         end
      end
      return 2 + mul_lat(w) * (pop + len);
   endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved (Blakley) modular multiplier: res = a*b mod m.
// Requires b < m; a may be any value. go loads, mdone pulses WIDTH+1 cycles later.
module mod_mul_serial #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] res,
   output logic             mdone
);
   import rsa_pkg::*;

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = WIDTH + 2;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_m;
   logic [PW-1:0]    r_p;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic             r_mdone;

   logic [PW-1:0]    w_p2;
   logic [PW-1:0]    w_s1;
   logic [PW-1:0]    w_s2;

   // One MSB-first step: P = 2P + a_i*b, then at most two subtractions of m.
   always_comb begin
      w_p2 = (r_p << 1) + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
      w_s1 = (w_p2 >= {2'b00, r_m}) ? w_p2 - {2'b00, r_m} : w_p2;
      w_s2 = (w_s1 >= {2'b00, r_m}) ? w_s1 - {2'b00, r_m} : w_s1;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         r_run   <= 1'b0;
         r_mdone <= 1'b0;
      end else begin
         r_mdone <= 1'b0;
         if (go) begin
            r_a   <= a;
            r_b   <= b;
            r_m   <= m;
            r_p   <= '0;
            r_cnt <= CW'(WIDTH);
            r_run <= 1'b1;
         end else if (r_run) begin
            r_p   <= w_s2;
            r_a   <= r_a << 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_run   <= 1'b0;
               r_mdone <= 1'b1;
            end
         end
      end
   end

   assign res   = r_p[WIDTH-1:0];
   assign mdone = r_mdone;

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation (right-to-left square-and-multiply) on one shared
// serial multiplier. Exponent-bit dispatch happens in each multiply's done cycle.
module mod_exp_engine #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] result
);
   import rsa_pkg::*;

   state_e           r_state;
   state_e           w_next;
   logic [WIDTH-1:0] r_base;
   logic [WIDTH-1:0] r_e;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_r;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic [WIDTH-1:0] r_result;

   logic             w_go;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_res;
   logic             w_mdone;
   logic [WIDTH-1:0] w_b_cur;
   logic [WIDTH-1:0] w_r_cur;
   logic [WIDTH-1:0] w_e_cur;

   mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .Rst   (Rst),
      .go    (w_go),
      .a     (w_op_a),
      .b     (w_op_b),
      .m     (r_m),
      .res   (w_res),
      .mdone (w_mdone)
   );

   // Forward the just-finished product so the next multiply can launch this cycle.
   assign w_b_cur = (w_mdone && r_state != MUL_R) ? w_res : r_b;
   assign w_r_cur = (w_mdone && r_state == MUL_R) ? w_res : r_r;
   assign w_e_cur = (w_mdone && r_state == SQR) ? (r_e >> 1) : r_e;

   always_ff @(posedge clk) begin
      if (Rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_go   = 1'b0;
      w_op_a = '0;
      w_op_b = '0;
      case (r_state)
         IDLE: if (start) w_next = CHECK;
         CHECK: begin
            if (r_m <= WIDTH'(1) || r_e == '0) begin
               w_next = FINISH;
            end else begin
               w_next = REDUCE;
               w_go   = 1'b1;
               w_op_a = r_base;
               w_op_b = WIDTH'(1);
            end
         end
         REDUCE, MUL_R, SQR: begin
            if (w_mdone) begin
               if (r_state == MUL_R)
                  w_next = (w_e_cur[WIDTH-1:1] == '0) ? FINISH : SQR;
               else if (w_e_cur == '0)
                  w_next = FINISH;
               else
                  w_next = w_e_cur[0] ? MUL_R : SQR;
               if (w_next == MUL_R) begin
                  w_go   = 1'b1;
                  w_op_a = w_r_cur;
                  w_op_b = w_b_cur;
               end else if (w_next == SQR) begin
                  w_go   = 1'b1;
                  w_op_a = w_b_cur;
                  w_op_b = w_b_cur;
               end
            end
         end
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         r_base   <= '0;
         r_e      <= '0;
         r_m      <= '0;
         r_b      <= '0;
         r_r      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         r_b    <= w_b_cur;
         r_r    <= w_r_cur;
         r_e    <= w_e_cur;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_base  <= base;
                  r_e     <= exponent;
                  r_m     <= modulus;
                  r_busy  <= 1'b1;
                  r_error <= 1'b0;
               end
            end
            CHECK: begin
               // Modulus 0/1 yields 0; otherwise r starts at 1 (also the e==0 answer).
               r_r     <= (r_m > WIDTH'(1)) ? WIDTH'(1) : '0;
               r_error <= (r_m == '0);
            end
            FINISH: begin
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_result <= r_r;
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign error  = r_error;
   assign result = r_result;

endmodule
